// File: rtl/apb2axi_pkg.sv
// Shared types and widths for the APB-to-AXI bridge: directory entries handed to
// the issue scheduler and the completion records that retire them.
package apb2axi_pkg;
  localparam int TAG_NUM    = 16;
  localparam int TAG_W      = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W   = 6;

  typedef struct packed {
    logic                  is_write;
    logic [TAG_W-1:0]      tag;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } directory_entry_t;

  typedef struct packed {
    logic             is_write;
    logic [TAG_W-1:0] tag;
  } completion_entry_t;

  localparam int REQ_WIDTH    = $bits(directory_entry_t);
  localparam int COMPLETION_W = $bits(completion_entry_t);
endpackage

// File: rtl/apb2axi_issue_sched_if.sv
// Bus bundle around the issue scheduler: directory pop ports, AXI AR/AW, completions.
// master = scheduler side, slave = directory/AXI/completion environment side.
interface apb2axi_issue_sched_if;
  import apb2axi_pkg::*;

  logic                    rd_req_valid;
  logic [REQ_WIDTH-1:0]    rd_req_entry;
  logic                    rd_req_ready;
  logic                    wr_req_valid;
  logic [REQ_WIDTH-1:0]    wr_req_entry;
  logic                    wr_req_ready;

  logic                    arvalid;
  logic                    arready;
  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;

  logic                    awvalid;
  logic                    awready;
  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;

  logic                    cpl_valid;
  logic [COMPLETION_W-1:0] cpl_entry;

  modport master (
    input  rd_req_valid, rd_req_entry, wr_req_valid, wr_req_entry,
    output rd_req_ready, wr_req_ready,
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    input  cpl_valid, cpl_entry
  );

  modport slave (
    output rd_req_valid, rd_req_entry, wr_req_valid, wr_req_entry,
    input  rd_req_ready, wr_req_ready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    output cpl_valid, cpl_entry
  );
endinterface

// File: rtl/apb2axi_issue_sched.sv
// Issue scheduler: pops one directory entry per cycle (round-robin rd/wr), drives
// registered AXI AR/AW, and tracks in-flight tags and outstanding counts.
module apb2axi_issue_sched
  import apb2axi_pkg::*;
#(
  parameter int MAX_OUTS_RD = 8,
  parameter int MAX_OUTS_WR = 8
) (
  input  logic                clk,
  input  logic                rst,
  apb2axi_issue_sched_if.master bus,
  output logic [TAG_NUM-1:0]  tag_busy,
  output logic [TAG_W:0]      rd_outs,
  output logic [TAG_W:0]      wr_outs,
  output logic                err_spurious
);

  typedef enum logic {PRIO_RD = 1'b0, PRIO_WR = 1'b1} prio_e;

  localparam logic [TAG_W:0] RD_LIM = (TAG_W+1)'(MAX_OUTS_RD);
  localparam logic [TAG_W:0] WR_LIM = (TAG_W+1)'(MAX_OUTS_WR);

  prio_e             rr_prio, rr_prio_nxt;
  directory_entry_t  rd_e, wr_e;
  completion_entry_t cpl_e;
  logic              rd_elig, wr_elig, grant_rd, grant_wr;
  logic              cpl_hit, cpl_rd, cpl_wr;
  logic [TAG_NUM-1:0] tag_busy_nxt;
  logic [TAG_W:0]    rd_outs_nxt, wr_outs_nxt;
  logic              unused_ok;

  assign rd_e  = bus.rd_req_entry;
  assign wr_e  = bus.wr_req_entry;
  assign cpl_e = bus.cpl_entry;
  // Direction is implied by which queue an entry arrives on.
  assign unused_ok = ^{rd_e.is_write, wr_e.is_write};

  assign bus.rd_req_ready = grant_rd;
  assign bus.wr_req_ready = grant_wr;

  // Eligibility looks only at registered state, so a completion freeing a tag
  // or an AXI handshake emptying a channel takes effect one cycle later.
  always_comb begin
    rd_elig = bus.rd_req_valid & ~bus.arvalid & (rd_outs < RD_LIM)
            & ~tag_busy[rd_e.tag] & ~rst;
    wr_elig = bus.wr_req_valid & ~bus.awvalid & (wr_outs < WR_LIM)
            & ~tag_busy[wr_e.tag] & ~rst;
    grant_rd    = 1'b0;
    grant_wr    = 1'b0;
    rr_prio_nxt = rr_prio;
    if (rd_elig && (!wr_elig || rr_prio == PRIO_RD)) grant_rd = 1'b1;
    else if (wr_elig)                                 grant_wr = 1'b1;
    if (grant_rd)      rr_prio_nxt = PRIO_WR;
    else if (grant_wr) rr_prio_nxt = PRIO_RD;
  end

  always_comb begin
    cpl_hit = bus.cpl_valid & tag_busy[cpl_e.tag];
    cpl_rd  = cpl_hit & ~cpl_e.is_write;
    cpl_wr  = cpl_hit &  cpl_e.is_write;
    tag_busy_nxt = tag_busy;
    if (cpl_hit)  tag_busy_nxt[cpl_e.tag] = 1'b0;
    if (grant_rd) tag_busy_nxt[rd_e.tag]  = 1'b1;
    if (grant_wr) tag_busy_nxt[wr_e.tag]  = 1'b1;
    rd_outs_nxt = rd_outs + (TAG_W+1)'(grant_rd) - (TAG_W+1)'(cpl_rd);
    wr_outs_nxt = wr_outs + (TAG_W+1)'(grant_wr) - (TAG_W+1)'(cpl_wr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_prio      <= PRIO_RD;
      tag_busy     <= '0;
      rd_outs      <= '0;
      wr_outs      <= '0;
      err_spurious <= 1'b0;
    end else begin
      rr_prio      <= rr_prio_nxt;
      tag_busy     <= tag_busy_nxt;
      rd_outs      <= rd_outs_nxt;
      wr_outs      <= wr_outs_nxt;
      err_spurious <= bus.cpl_valid & ~cpl_hit;
    end
  end

  // AR channel: load on pop, hold until handshake, then drop for one bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.arvalid <= 1'b0;
      bus.arid    <= '0;
      bus.araddr  <= '0;
      bus.arlen   <= '0;
      bus.arsize  <= '0;
      bus.arburst <= '0;
    end else if (grant_rd) begin
      bus.arvalid <= 1'b1;
      bus.arid    <= AXI_ID_W'(rd_e.tag);
      bus.araddr  <= rd_e.addr;
      bus.arlen   <= rd_e.len;
      bus.arsize  <= rd_e.size;
      bus.arburst <= rd_e.burst;
    end else if (bus.arvalid && bus.arready) begin
      bus.arvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.awvalid <= 1'b0;
      bus.awid    <= '0;
      bus.awaddr  <= '0;
      bus.awlen   <= '0;
      bus.awsize  <= '0;
      bus.awburst <= '0;
    end else if (grant_wr) begin
      bus.awvalid <= 1'b1;
      bus.awid    <= AXI_ID_W'(wr_e.tag);
      bus.awaddr  <= wr_e.addr;
      bus.awlen   <= wr_e.len;
      bus.awsize  <= wr_e.size;
      bus.awburst <= wr_e.burst;
    end else if (bus.awvalid && bus.awready) begin
      bus.awvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb2axi_issue_sched.sv
// Directed bench for apb2axi_issue_sched: per-cycle vector table for arbitration and
// accounting, plus hand-written sequences for AXI backpressure, payloads and reset.
module tb_apb2axi_issue_sched;
  import apb2axi_pkg::*;

  logic clk, rst;
  logic [TAG_NUM-1:0] tag_busy;
  logic [TAG_W:0]     rd_outs, wr_outs;
  logic               err_spurious;
  int n_tests = 0;
  int n_fail  = 0;

  apb2axi_issue_sched_if bus ();

  apb2axi_issue_sched #(.MAX_OUTS_RD(2), .MAX_OUTS_WR(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .tag_busy     (tag_busy),
    .rd_outs      (rd_outs),
    .wr_outs      (wr_outs),
    .err_spurious (err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic rv; int rt; logic wv; int wt; logic cv; logic cw; int ct;
    logic e_rr; logic e_wr; logic e_arv; logic e_awv; int e_ro; int e_wo; logic e_err;
    logic [15:0] e_busy;
  } vec_t;

  vec_t vt [20];

  function automatic vec_t mk(logic r, logic rv, int rt, logic wv, int wt,
                              logic cv, logic cw, int ct,
                              logic err_rr, logic ewr, logic earv, logic eawv,
                              int ero, int ewo, logic eerr, logic [15:0] ebusy);
    vec_t v;
    v.rst = r; v.rv = rv; v.rt = rt; v.wv = wv; v.wt = wt;
    v.cv = cv; v.cw = cw; v.ct = ct;
    v.e_rr = err_rr; v.e_wr = ewr; v.e_arv = earv; v.e_awv = eawv;
    v.e_ro = ero; v.e_wo = ewo; v.e_err = eerr; v.e_busy = ebusy;
    return v;
  endfunction

  function automatic directory_entry_t ent(logic w, int tag, logic [31:0] addr,
                                           logic [7:0] len, logic [2:0] sz);
    directory_entry_t e;
    e.is_write = w;
    e.tag      = TAG_W'(tag);
    e.addr     = addr;
    e.len      = len;
    e.size     = sz;
    e.burst    = 2'b01;
    return e;
  endfunction

  function automatic completion_entry_t cpl(logic w, int tag);
    completion_entry_t c;
    c.is_write = w;
    c.tag      = TAG_W'(tag);
    return c;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rd_req_valid = 1'b0;
    bus.wr_req_valid = 1'b0;
    bus.cpl_valid    = 1'b0;
    bus.rd_req_entry = '0;
    bus.wr_req_entry = '0;
    bus.cpl_entry    = '0;
  endtask

  initial begin
    logic [30:0] obs, exp;
    rst = 1'b1;
    idle_inputs();
    bus.arready = 1'b1;
    bus.awready = 1'b1;

    // rows: rst rv rt wv wt | cv cw ct | rr wr arv awv ro wo err busy
    vt[0]  = mk(1,1,0, 1,1,  0,0,0,  0,0,0,0, 0,0,0, 16'h0000);
    vt[1]  = mk(1,1,0, 1,1,  0,0,0,  0,0,0,0, 0,0,0, 16'h0000);
    vt[2]  = mk(0,1,0, 1,8,  0,0,0,  1,0,0,0, 0,0,0, 16'h0000);
    vt[3]  = mk(0,1,1, 1,8,  0,0,0,  0,1,1,0, 1,0,0, 16'h0001);
    vt[4]  = mk(0,1,1, 1,9,  0,0,0,  1,0,0,1, 1,1,0, 16'h0101);
    vt[5]  = mk(0,1,2, 1,9,  0,0,0,  0,1,1,0, 2,1,0, 16'h0103);
    vt[6]  = mk(0,1,2, 0,0,  0,0,0,  0,0,0,1, 2,2,0, 16'h0303);
    vt[7]  = mk(0,1,2, 0,0,  1,0,1,  0,0,0,0, 2,2,0, 16'h0303);
    vt[8]  = mk(0,1,2, 0,0,  0,0,0,  1,0,0,0, 1,2,0, 16'h0301);
    vt[9]  = mk(0,0,0, 0,0,  0,0,0,  0,0,1,0, 2,2,0, 16'h0305);
    vt[10] = mk(0,0,0, 1,8,  0,0,0,  0,0,0,0, 2,2,0, 16'h0305);
    vt[11] = mk(0,0,0, 1,8,  1,1,8,  0,0,0,0, 2,2,0, 16'h0305);
    vt[12] = mk(0,0,0, 1,8,  0,0,0,  0,1,0,0, 2,1,0, 16'h0205);
    vt[13] = mk(0,0,0, 0,0,  1,1,4,  0,0,0,1, 2,2,0, 16'h0305);
    vt[14] = mk(0,0,0, 0,0,  0,0,0,  0,0,0,0, 2,2,1, 16'h0305);
    vt[15] = mk(0,0,0, 1,10, 1,1,9,  0,1,0,0, 2,2,0, 16'h0305);
    vt[16] = mk(0,0,0, 0,0,  0,0,0,  0,0,0,1, 2,2,0, 16'h0505);
    vt[17] = mk(0,0,0, 1,11, 0,0,0,  0,1,0,0, 2,2,0, 16'h0505);
    vt[18] = mk(0,0,0, 1,12, 0,0,0,  0,0,0,1, 2,3,0, 16'h0D05);
    vt[19] = mk(0,0,0, 1,12, 0,0,0,  0,0,0,0, 2,3,0, 16'h0D05);

    @(posedge clk);
    foreach (vt[i]) begin
      @(negedge clk);
      rst              = vt[i].rst;
      bus.rd_req_valid = vt[i].rv;
      bus.rd_req_entry = ent(1'b0, vt[i].rt, 32'h1000 + 32'(vt[i].rt) * 256, 8'(vt[i].rt), 3'd2);
      bus.wr_req_valid = vt[i].wv;
      bus.wr_req_entry = ent(1'b1, vt[i].wt, 32'h8000 + 32'(vt[i].wt) * 256, 8'(vt[i].wt), 3'd2);
      bus.cpl_valid    = vt[i].cv;
      bus.cpl_entry    = cpl(vt[i].cw, vt[i].ct);
      #1;
      obs = {bus.rd_req_ready, bus.wr_req_ready, bus.arvalid, bus.awvalid,
             rd_outs, wr_outs, err_spurious, tag_busy};
      exp = {vt[i].e_rr, vt[i].e_wr, vt[i].e_arv, vt[i].e_awv,
             5'(vt[i].e_ro), 5'(vt[i].e_wo), vt[i].e_err, vt[i].e_busy};
      chk($sformatf("vec%0d", i), 64'(obs), 64'(exp));
    end

    // Single read, then AR backpressure for five cycles.
    @(negedge clk); rst = 1'b1; idle_inputs(); bus.arready = 1'b0; bus.awready = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    bus.rd_req_valid = 1'b1;
    bus.rd_req_entry = ent(1'b0, 3, 32'h1000, 8'd7, 3'd3);
    #1 chk("rd_pop_n", 64'(bus.rd_req_ready), 64'd1);
    @(negedge clk);
    bus.rd_req_entry = ent(1'b0, 4, 32'h2000, 8'd1, 3'd2);
    #1;
    chk("ar_valid_n1", 64'(bus.arvalid), 64'd1);
    chk("ar_id_n1",    64'(bus.arid), 64'd3);
    chk("ar_addr_n1",  64'(bus.araddr), 64'h1000);
    chk("ar_len_size", 64'({bus.arlen, bus.arsize, bus.arburst}), 64'({8'd7, 3'd3, 2'b01}));
    chk("rd_outs_1",   64'(rd_outs), 64'd1);
    chk("busy_tag3",   64'(tag_busy), 64'h0008);
    chk("no_pop_held", 64'(bus.rd_req_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk($sformatf("ar_hold%0d", k),
          64'({bus.arvalid, bus.rd_req_ready, bus.arid, bus.araddr}),
          64'({1'b1, 1'b0, 6'd3, 32'h1000}));
    end
    @(negedge clk); bus.arready = 1'b1;
    #1 chk("ar_hs_cycle", 64'({bus.arvalid, bus.rd_req_ready}), 64'({1'b1, 1'b0}));
    @(negedge clk); bus.arready = 1'b0;
    #1 chk("ar_dropped", 64'({bus.arvalid, bus.rd_req_ready}), 64'({1'b0, 1'b1}));
    @(negedge clk); bus.rd_req_valid = 1'b0;
    #1 chk("ar_second", 64'({bus.arvalid, bus.arid, bus.araddr, rd_outs}),
           64'({1'b1, 6'd4, 32'h2000, 5'd2}));

    // Reset while AR is held drops it without a handshake.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 chk("rst_mid_burst", 64'({bus.arvalid, bus.araddr, rd_outs, tag_busy}), 64'd0);

    // Write payload, then a spurious completion for an idle tag.
    @(negedge clk);
    bus.wr_req_valid = 1'b1;
    bus.wr_req_entry = ent(1'b1, 5, 32'h3000, 8'd2, 3'd2);
    #1 chk("wr_pop", 64'({bus.wr_req_ready, bus.rd_req_ready}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    bus.wr_req_valid = 1'b0;
    bus.cpl_valid    = 1'b1;
    bus.cpl_entry    = cpl(1'b1, 9);
    #1 chk("aw_payload", 64'({bus.awvalid, bus.awid, bus.awaddr, bus.awlen, wr_outs}),
           64'({1'b1, 6'd5, 32'h3000, 8'd2, 5'd1}));
    @(negedge clk); bus.cpl_valid = 1'b0;
    #1 chk("spurious_pulse", 64'({err_spurious, rd_outs, wr_outs, tag_busy}),
           64'({1'b1, 5'd0, 5'd1, 16'h0020}));
    @(negedge clk);
    #1 chk("spurious_1cyc", 64'(err_spurious), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
